mem_access_unit: RTL and testbench

//  Memory-access (MEM) stage of the processor pipeline: takes one load/store request from EX,

---
 rtl/mem_access_unit_pkg.sv | 22 ++
 rtl/dmem_align.sv | 58 +++++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage.
// Contents:
//   SIZE_WORD/HALF/BYTE  access-size encodings used on req_size and the SIZE bus output
//   state_e              FSM states of the bus sequencer
//   norm_size()          folds the reserved size code 2'b11 onto byte
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic {
        StIdle = 1'b0,
        StBus  = 1'b1
    } state_e;

    // 2'b11 behaves exactly like a byte access everywhere, including on SIZE.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SIZE_WORD || size == SIZE_HALF) ? size : SIZE_BYTE;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational data formatter for the memory-access stage.
// Ports:
//   req_size_i, req_addr_lo_i  incoming request size/low address bits -> misaligned_o
//   size_i, signed_i           size (already normalised) and signedness of the active access
//   wdata_i                    right-aligned store data -> store_data_o (value to drive on DDT)
//   rdata_i                    raw DDT contents on a load -> load_data_o (extended result)
// Sub-word data lives in the low bits of the bus; bits above the access size are ignored.
module dmem_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic [1:0]       req_size_i,
    input  logic [1:0]       req_addr_lo_i,
    output logic             misaligned_o,
    input  logic [1:0]       size_i,
    input  logic             signed_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] rdata_i,
    output logic [Width-1:0] store_data_o,
    output logic [Width-1:0] load_data_o
);

    logic half_sign;
    logic byte_sign;

    assign half_sign = signed_i & rdata_i[15];
    assign byte_sign = signed_i & rdata_i[7];

    always_comb begin
        misaligned_o = 1'b0;
        unique case (norm_size(req_size_i))
            SIZE_WORD: misaligned_o = (req_addr_lo_i != 2'b00);
            SIZE_HALF: misaligned_o = req_addr_lo_i[0];
            default:   misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        store_data_o = wdata_i;
        load_data_o  = rdata_i;
        case (size_i)
            SIZE_WORD: begin
                store_data_o = wdata_i;
                load_data_o  = rdata_i;
            end
            SIZE_HALF: begin
                store_data_o = {{(Width - 16){1'b0}}, wdata_i[15:0]};
                load_data_o  = {{(Width - 16){half_sign}}, rdata_i[15:0]};
            end
            default: begin
                store_data_o = {{(Width - 8){1'b0}}, wdata_i[7:0]};
                load_data_o  = {{(Width - 8){byte_sign}}, rdata_i[7:0]};
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access (MEM) pipeline stage: accepts one load/store from EX, runs a single data-bus
// transaction and hands the formatted result to WB.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake from EX (ready only while idle)
//   req_write/size/signed/addr/
//   req_wdata/req_rd               request fields, captured at acceptance
//   wb_valid/wb_we/wb_rd/wb_data   one-cycle completion pulse and load result for WB
//   bus_err                        one-cycle pulse on misaligned request or acknowledge timeout
//   DAD/MREQ/WRITE/SIZE            data-bus address and control, held stable during a cycle
//   DDT                            bidirectional data bus, driven only by stores
//   ACKD_n                         active-low bus acknowledge
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 32,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [4:0]           wb_rd,
    output logic [BIT_WIDTH-1:0] wb_data,
    output logic                 bus_err,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    input  logic                 ACKD_n
);

    localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [BIT_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]             size_q, size_d;
    logic                   write_q, write_d;
    logic                   signed_q, signed_d;
    logic [BIT_WIDTH-1:0]   wdata_q, wdata_d;
    logic [4:0]             rd_q, rd_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   wb_valid_q, wb_valid_d;
    logic                   wb_we_q, wb_we_d;
    logic [4:0]             wb_rd_q, wb_rd_d;
    logic [BIT_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                   bus_err_q, bus_err_d;

    logic                   misaligned;
    logic [BIT_WIDTH-1:0]   store_data;
    logic [BIT_WIDTH-1:0]   load_data;

    dmem_align #(
        .Width (BIT_WIDTH)
    ) u_align (
        .req_size_i    (req_size),
        .req_addr_lo_i (req_addr[1:0]),
        .misaligned_o  (misaligned),
        .size_i        (size_q),
        .signed_i      (signed_q),
        .wdata_i       (wdata_q),
        .rdata_i       (DDT),
        .store_data_o  (store_data),
        .load_data_o   (load_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        signed_d   = signed_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        bus_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (misaligned) begin
                        // Rejected without touching the bus; WB still sees a completion.
                        bus_err_d  = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = req_rd;
                        wb_data_d  = '0;
                    end else begin
                        addr_d   = req_addr;
                        size_d   = norm_size(req_size);
                        write_d  = req_write;
                        signed_d = req_signed;
                        wdata_d  = req_wdata;
                        rd_d     = req_rd;
                        cnt_d    = '0;
                        state_d  = StBus;
                    end
                end
            end
            StBus: begin
                // Acknowledge is checked first so it wins over a same-edge timeout.
                if (!ACKD_n) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = !write_q && (rd_q != 5'd0);
                    wb_rd_d    = rd_q;
                    wb_data_d  = write_q ? '0 : load_data;
                end else if (cnt_q == CntLast) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = '0;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            size_q     <= SIZE_WORD;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            wdata_q    <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            signed_q   <= signed_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign MREQ      = (state_q == StBus);
    assign DAD       = addr_q;
    assign SIZE      = size_q;
    assign WRITE     = write_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign bus_err   = bus_err_q;

    assign DDT = (MREQ && write_q) ? store_data : {BIT_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a byte-array memory answers bus cycles with a
// chosen acknowledge latency; expected results come from the memory contents and plain
// arithmetic on the request.
module tb_mem_access_unit;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        bus_err;
    logic [31:0] dad;
    logic        mreq;
    logic        write;
    logic [1:0]  size;
    wire  [31:0] ddt;
    logic        ackd_n;

    logic        drv_en;
    logic [31:0] drv_val;
    assign ddt = drv_en ? drv_val : 32'bz;

    logic [7:0] mem [0:1023];
    int vectors = 0;
    int miscompares = 0;

    mem_access_unit #(
        .BIT_WIDTH   (32),
        .ACK_TIMEOUT (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .bus_err    (bus_err),
        .DAD        (dad),
        .MREQ       (mreq),
        .WRITE      (write),
        .SIZE       (size),
        .DDT        (ddt),
        .ACKD_n     (ackd_n)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus not driven by the DUT: a pattern driven by the bench must read back unchanged.
    task automatic check_ddt_released(input string tag);
        drv_en  = 1'b1;
        drv_val = 32'hA5A5_5A5A;
        #1;
        check(tag, ddt, 32'hA5A5_5A5A);
        drv_en = 1'b0;
    endtask

    // lat = bus cycle (1-based) in which ACKD_n goes low; 0 = never acknowledge.
    task automatic do_access(input logic wr, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, input int lat);
        logic [1:0]  nsz;
        bit          mis;
        bit          acked;
        int          nbus;
        int          a;
        int          v;
        logic [31:0] exp_ld;
        logic [31:0] exp_st;
        logic [31:0] bus_word;
        logic [31:0] r;
        logic [31:0] mem_obs;
        logic [31:0] mem_exp;

        nsz = (sz == 2'b11) ? 2'b10 : sz;
        mis = (nsz == 2'b00 && addr[1:0] != 2'b00) || (nsz == 2'b01 && addr[0]);
        a   = int'(addr[9:0]);
        r   = $urandom();
        exp_ld = 32'h0; exp_st = 32'h0; bus_word = 32'h0;
        if (!mis) begin
            if (nsz == 2'b00) begin
                exp_ld   = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
                bus_word = exp_ld;
                exp_st   = wdata;
            end else if (nsz == 2'b01) begin
                v = int'(mem[a]) * 256 + int'(mem[a+1]);
                if (sgn && v >= 32768) v = v - 65536;
                exp_ld   = 32'(v);
                bus_word = {r[31:16], mem[a], mem[a+1]};
                exp_st   = wdata & 32'h0000_FFFF;
            end else begin
                v = int'(mem[a]);
                if (sgn && v >= 128) v = v - 256;
                exp_ld   = 32'(v);
                bus_word = {r[31:8], mem[a]};
                exp_st   = wdata & 32'h0000_00FF;
            end
        end

        @(negedge clk);
        check("req_ready_before", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;

        if (mis) begin
            check("mis_mreq", mreq, 0);
            check("mis_bus_err", bus_err, 1);
            check("mis_wb_valid", wb_valid, 1);
            check("mis_wb_we", wb_we, 0);
            check("mis_req_ready", req_ready, 1);
            @(posedge clk); #1;
            check("mis_bus_err_pulse", bus_err, 0);
            check("mis_wb_valid_pulse", wb_valid, 0);
            return;
        end

        acked = (lat >= 1) && (lat <= int'(T));
        nbus  = acked ? lat : int'(T);
        for (int c = 1; c <= nbus; c++) begin
            check("bus_mreq", mreq, 1);
            check("bus_req_ready", req_ready, 0);
            check("bus_wb_valid", wb_valid, 0);
            if (c == 1) begin
                check("bus_dad", dad, addr);
                check("bus_size", size, nsz);
                check("bus_write", write, wr);
            end
            if (wr) check("bus_ddt_store", ddt, exp_st);
            if (c == lat) begin
                ackd_n = 1'b0;
                if (wr) begin
                    if (nsz == 2'b00) begin
                        mem[a] = ddt[31:24]; mem[a+1] = ddt[23:16];
                        mem[a+2] = ddt[15:8]; mem[a+3] = ddt[7:0];
                    end else if (nsz == 2'b01) begin
                        mem[a] = ddt[15:8]; mem[a+1] = ddt[7:0];
                    end else begin
                        mem[a] = ddt[7:0];
                    end
                end else begin
                    drv_en  = 1'b1;
                    drv_val = bus_word;
                end
            end
            @(posedge clk); #1;
            ackd_n = 1'b1;
            drv_en = 1'b0;
        end

        check("done_mreq", mreq, 0);
        check("done_wb_valid", wb_valid, 1);
        check("done_bus_err", bus_err, acked ? 0 : 1);
        check("done_wb_we", wb_we, (acked && !wr && rd != 5'd0) ? 1 : 0);
        if (acked) begin
            check("done_wb_rd", wb_rd, rd);
            check("done_wb_data", wb_data, wr ? 32'h0 : exp_ld);
        end
        if (acked && wr) begin
            if (nsz == 2'b00) begin
                mem_obs = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
                mem_exp = wdata;
            end else if (nsz == 2'b01) begin
                mem_obs = {16'h0, mem[a], mem[a+1]};
                mem_exp = wdata & 32'h0000_FFFF;
            end else begin
                mem_obs = {24'h0, mem[a]};
                mem_exp = wdata & 32'h0000_00FF;
            end
            check("store_mem_bytes", mem_obs, mem_exp);
        end
        @(posedge clk); #1;
        check("after_wb_valid", wb_valid, 0);
        check("after_bus_err", bus_err, 0);
        check("after_req_ready", req_ready, 1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] addr;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; ackd_n = 1'b1;
        drv_en = 1'b0; drv_val = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom());

        @(posedge clk); @(posedge clk); #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_mreq", mreq, 0);
        check("rst_write", write, 0);
        check("rst_size", size, 2'b00);
        check("rst_dad", dad, 32'h0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_bus_err", bus_err, 0);
        check_ddt_released("rst_ddt");
        rst = 1'b0;

        // Word load, big-endian, ACK in first bus cycle.
        mem[256] = 8'h12; mem[257] = 8'h34; mem[258] = 8'h56; mem[259] = 8'h78;
        do_access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 5'd5, 1);
        check("word_load_literal", wb_data, 32'h1234_5678);

        // Byte loads of 0x80, signed and unsigned; half load of 0x8001 signed.
        mem[384] = 8'h80;
        do_access(1'b0, 2'b10, 1'b1, 32'h180, 32'h0, 5'd7, 1);
        check("byte_signed_literal", wb_data, 32'hFFFF_FF80);
        do_access(1'b0, 2'b10, 1'b0, 32'h180, 32'h0, 5'd7, 2);
        check("byte_unsigned_literal", wb_data, 32'h0000_0080);
        mem[400] = 8'h80; mem[401] = 8'h01;
        do_access(1'b0, 2'b01, 1'b1, 32'h190, 32'h0, 5'd9, 1);
        check("half_signed_literal", wb_data, 32'hFFFF_8001);

        // Half store: memory bytes BE EF at 0x202/0x203.
        do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'hDEAD_BEEF, 5'd3, 2);
        check("half_store_byte0", mem[514], 8'hBE);
        check("half_store_byte1", mem[515], 8'hEF);

        // Misaligned word load, misaligned half store.
        do_access(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 5'd4, 1);
        do_access(1'b1, 2'b01, 1'b0, 32'h203, 32'h1234_5678, 5'd4, 1);

        // No acknowledge: timeout after T bus cycles; ACK on the last cycle wins.
        do_access(1'b0, 2'b00, 1'b0, 32'h040, 32'h0, 5'd6, 0);
        do_access(1'b0, 2'b00, 1'b0, 32'h044, 32'h0, 5'd6, int'(T));

        // Byte load to r0 with ACK latency 3; reserved size code behaves as byte.
        do_access(1'b0, 2'b10, 1'b1, 32'h055, 32'h0, 5'd0, 3);
        do_access(1'b0, 2'b11, 1'b1, 32'h057, 32'h0, 5'd8, 1);

        // Reset during the second bus cycle of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h300; req_wdata = 32'h0000_0081; req_rd = 5'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstbus_mreq_c1", mreq, 1);
        check("rstbus_ddt_c1", ddt, 32'h0000_0081);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstbus_mreq", mreq, 0);
        check("rstbus_wb_valid", wb_valid, 0);
        check("rstbus_bus_err", bus_err, 0);
        check("rstbus_req_ready", req_ready, 1);
        check_ddt_released("rstbus_ddt");
        @(posedge clk); #1;
        check("rstbus_wb_valid_later", wb_valid, 0);
        check("rstbus_bus_err_later", bus_err, 0);

        // Randomised accesses.
        for (int n = 0; n < 40; n++) begin
            sz   = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 1019));
            if ($urandom_range(0, 7) != 0) begin
                if (sz == 2'b00) addr[1:0] = 2'b00;
                else if (sz == 2'b01) addr[0] = 1'b0;
            end
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
                      $urandom(), 5'($urandom_range(0, 31)), $urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
